eth_pcs_tx_gearbox: RTL and testbench

- 64b/66b TX gearbox for the 10GBASE-R PCS transmit path.
- Sits between the TX scrambler (66-bit blocks: sync header plus scrambled payload) and the 64-bit PMA interface.
- Packs 32 input blocks (2112 bits) into 33 output words, throttling upstream with o_ready once per 33-cycle frame.
- It produces the bitstream that the RX block synchronizer locks onto on the far end.

---
 rtl/eth_pcs_tx_gearbox_pkg.sv | 17 +
 rtl/eth_pcs_tx_gearbox.sv | 68 ++++++
 tb/tb_eth_pcs_tx_gearbox.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/eth_pcs_tx_gearbox_pkg.sv
// Shared PCS widths and block type for the 64b/66b transmit path.
// The sync header sits in the low bits so it is transmitted first.
package eth_pcs_params;
    localparam int W_SYNC     = 2;
    localparam int W_BLK_PLD  = 64;
    localparam int W_GB_OUT   = 64;
    localparam int GB_SEQ_LEN = 33;
    localparam int W_GB_SEQ   = $clog2(GB_SEQ_LEN);
    localparam int W_BLK      = W_BLK_PLD + W_SYNC;

    localparam logic [W_GB_SEQ-1:0] GB_SEQ_LAST = W_GB_SEQ'(GB_SEQ_LEN - 1);

    typedef struct packed {
        logic [W_BLK_PLD-1:0] payload;
        logic [W_SYNC-1:0]    sync;
    } eth_blk_t;
endpackage

// File: rtl/eth_pcs_tx_gearbox.sv
// 66b -> 64b TX gearbox: 32 blocks become 33 words; the last word of each
// frame flushes the 64-bit leftover while upstream is held off.
module eth_pcs_tx_gearbox
    import eth_pcs_params::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic [W_SYNC-1:0]    i_sync_hdr,
    input  logic [W_BLK_PLD-1:0] i_data,
    output logic                 o_ready,
    output logic [W_GB_OUT-1:0]  o_data,
    output logic                 o_valid
);
    localparam int W_COMB = 2 * W_GB_OUT;

    logic [W_GB_SEQ-1:0] seq_reg, seq_next;
    logic [W_GB_OUT-1:0] left_reg, left_next;
    logic [W_GB_OUT-1:0] data_reg, data_next;
    logic                valid_reg, valid_next;

    eth_blk_t            blk;
    logic [W_GB_SEQ-1:0] shamt;
    logic [W_COMB-1:0]   comb;

    assign o_ready = (seq_reg != GB_SEQ_LAST);
    assign o_data  = data_reg;
    assign o_valid = valid_reg;

    always_comb begin
        blk.payload = i_data;
        blk.sync    = i_sync_hdr;
        // Leftover holds 2k bits at step k, so the new block lands at bit 2k.
        shamt       = {seq_reg[W_GB_SEQ-2:0], 1'b0};
        comb        = {{(W_COMB-W_GB_OUT){1'b0}}, left_reg} | (W_COMB'(blk) << shamt);

        seq_next   = seq_reg;
        left_next  = left_reg;
        data_next  = data_reg;
        valid_next = 1'b0;

        if (seq_reg == GB_SEQ_LAST) begin
            data_next  = left_reg;
            valid_next = 1'b1;
            left_next  = '0;
            seq_next   = '0;
        end else if (i_valid) begin
            data_next  = comb[W_GB_OUT-1:0];
            valid_next = 1'b1;
            left_next  = comb[W_COMB-1:W_GB_OUT];
            seq_next   = seq_reg + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            seq_reg   <= '0;
            left_reg  <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            seq_reg   <= seq_next;
            left_reg  <= left_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
        end
    end
endmodule

// File: tb/tb_eth_pcs_tx_gearbox.sv
// Bench for the TX gearbox: a bit-serial scoreboard checks every output word
// against the accepted input bitstream, plus directed checks on handshake and reset.
module tb_eth_pcs_tx_gearbox;
    import eth_pcs_params::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [1:0]  hdr = 2'b00;
    logic [63:0] data = '0;
    logic        ready;
    logic        ovalid;
    logic [63:0] odata;

    int n_cmp = 0;
    int n_bad = 0;
    int accepted = 0;
    int words = 0;
    int mseq = 0;
    bit known = 1'b0;
    bit bitq[$];

    always #5 clk = ~clk;

    eth_pcs_tx_gearbox dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_valid    (valid),
        .i_sync_hdr (hdr),
        .i_data     (data),
        .o_ready    (ready),
        .o_data     (odata),
        .o_valid    (ovalid)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; the bit queue receives exactly what the DUT should accept.
    task automatic drive(input bit v, input logic [1:0] h, input logic [63:0] d, input bit r);
        @(negedge clk);
        if (known) check("o_ready", 64'(ready), 64'(mseq != 32));
        reset = r;
        valid = v;
        hdr   = h;
        data  = d;
        if (r) begin
            bitq.delete();
            mseq  = 0;
            known = 1'b1;
        end else if (mseq == 32) begin
            mseq = 0;
        end else if (v) begin
            for (int i = 0; i < 2; i++) bitq.push_back(h[i]);
            for (int i = 0; i < 64; i++) bitq.push_back(d[i]);
            mseq++;
            accepted++;
        end
        $display("cyc: rst=%0b vld=%0b hdr=%b data=%h seq_model=%0d", r, v, h, d, mseq);
    endtask

    // Monitor: every presented word must equal the next 64 queued bits.
    initial begin
        forever begin
            logic [63:0] e;
            @(posedge clk);
            #1;
            if (ovalid === 1'b1) begin
                e = '0;
                if (bitq.size() < 64) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_underflow: got word %h with only %0d bits expected", odata, bitq.size());
                end else begin
                    for (int i = 0; i < 64; i++) e[i] = bitq.pop_front();
                    check("sb_word", odata, e);
                    words++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int acc0;
        logic [65:0] blk;
        logic [63:0] expw;

        // Reset held 3 cycles with valid asserted: nothing may be accepted.
        for (int i = 0; i < 3; i++) drive(1'b1, 2'b10, 64'hDEAD_BEEF_0000_1111, 1'b1);
        @(posedge clk); #1;
        check("rst_o_valid", 64'(ovalid), 64'd0);
        check("rst_o_data", odata, 64'd0);
        check("rst_o_ready", 64'(ready), 64'd1);

        // First two words, hand-computed.
        drive(1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        @(posedge clk); #1;
        check("word0", odata, 64'hFFFF_FFFF_FFFF_FFFE);
        drive(1'b1, 2'b01, 64'h0, 1'b0);
        @(posedge clk); #1;
        check("word1", odata, 64'h0000_0000_0000_0007);

        // Stall at step 5: two idle cycles, stream must stay contiguous.
        drive(1'b0, 2'b00, 64'h0, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, 2'(i), {32'h1234_0000 + 32'(i), 32'hCAFE_F00D}, 1'b0);
        drive(1'b0, 2'b01, 64'h0, 1'b0);
        drive(1'b0, 2'b01, 64'h0, 1'b0);
        check("stall_o_valid1", 64'(ovalid), 64'd0);
        drive(1'b1, 2'b01, 64'h0123_4567_89AB_CDEF, 1'b0);
        check("stall_o_valid2", 64'(ovalid), 64'd0);
        for (int i = 0; i < 40; i++) drive(1'b1, 2'b10, {32'(i), 32'h5A5A_0000 ^ 32'(i * 7)}, 1'b0);

        // Mid-frame reset at step 20, block presented alongside reset is dropped.
        drive(1'b0, 2'b00, 64'h0, 1'b1);
        for (int i = 0; i < 20; i++) drive(1'b1, 2'b01, {32'(i), 32'h0F0F_0F0F}, 1'b0);
        drive(1'b1, 2'b10, 64'hBAD0_BAD0_BAD0_BAD0, 1'b1);
        @(posedge clk); #1;
        check("mrst_o_valid", 64'(ovalid), 64'd0);
        check("mrst_o_data", odata, 64'd0);
        drive(1'b1, 2'b11, 64'hA5A5_5A5A_C3C3_3C3C, 1'b0);
        @(posedge clk); #1;
        blk  = {64'hA5A5_5A5A_C3C3_3C3C, 2'b11};
        expw = blk[63:0];
        check("mrst_first_word", odata, expw);

        // Throttle: continuous valid for 330 cycles.
        drive(1'b0, 2'b00, 64'h0, 1'b1);
        acc0 = accepted;
        for (int i = 0; i < 330; i++) begin
            drive(1'b1, 2'b00, {32'hF00D_0000 + 32'(i), 32'(i * 3)}, 1'b0);
            if (i >= 1) check("thr_o_valid", 64'(ovalid), 64'd1);
        end
        check("thr_accepted", 64'(accepted - acc0), 64'd320);

        // Ten frames of random blocks with occasional stalls.
        drive(1'b0, 2'b00, 64'h0, 1'b1);
        acc0 = accepted;
        while (accepted - acc0 < 320) begin
            drive(($urandom_range(0, 6) != 0), 2'($urandom), {$urandom, $urandom}, 1'b0);
        end
        // Drive until the last flush word of the tenth frame has been presented.
        while (mseq != 0) drive(1'b0, 2'b00, 64'h0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, 64'h0, 1'b0);
        check("rand_queue_empty", 64'(bitq.size()), 64'd0);
        check("words_seen_nonzero", 64'(words > 300), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
